// File: rtl/apb_req_arb_pkg.sv
// rtl/apb_req_arb_pkg.sv - shared FSM state type and slave-index width helper
package apb_req_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_req_arb_if.sv
// rtl/apb_req_arb_if.sv - requester and APB bus bundle for apb_req_arb
interface apb_req_arb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int DEC_NUMBER = 16,
  parameter int REQ_NUMBER = 4
);
  logic [REQ_NUMBER-1:0]            req_valid_i;
  logic [REQ_NUMBER-1:0]            req_write_i;
  logic [REQ_NUMBER*ADDR_WIDTH-1:0] req_addr_i;
  logic [REQ_NUMBER*DATA_WIDTH-1:0] req_wdata_i;
  logic [REQ_NUMBER-1:0]            req_ready_o;
  logic [REQ_NUMBER-1:0]            rsp_valid_o;
  logic [DATA_WIDTH-1:0]            rsp_rdata_o;
  logic [ADDR_WIDTH-1:0]            paddr_o;
  logic                             penable_o;
  logic [DEC_NUMBER-1:0]            pselx_o;
  logic                             pwrite_o;
  logic [DATA_WIDTH-1:0]            pwdata_o;
  logic [DATA_WIDTH-1:0]            prdata_i;

  modport master (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, prdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o,
    output paddr_o, penable_o, pselx_o, pwrite_o, pwdata_o
  );

  modport slave (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, prdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o,
    input  paddr_o, penable_o, pselx_o, pwrite_o, pwdata_o
  );
endinterface

// File: rtl/apb_req_arb_rr_arbiter.sv
// rtl/apb_req_arb_rr_arbiter.sv - round-robin request to one-hot grant with rotating pointer
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx
);
  logic [W-1:0] ptr;
  logic [W-1:0] idx;
  logic         found;
  int           pos;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    pos       = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      idx = W'(pos);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  // Search resumes just past the last winner.
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (advance)
      ptr <= (grant_idx == W'(N-1)) ? '0 : grant_idx + 1'b1;
  end

endmodule

// File: rtl/apb_req_arb.sv
// rtl/apb_req_arb.sv - multi-requester APB master; APB_REQ_ARB_FIXED_PRIO_EN selects fixed priority
module apb_req_arb
  import apb_req_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int DEC_NUMBER = 16,
  parameter int DEC_LSB    = 12,
  parameter int REQ_NUMBER = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  apb_req_arb_if.master bus
);
  localparam int IW = idx_width(DEC_NUMBER);
  localparam int RW = $clog2(REQ_NUMBER);

  state_t                state, state_nxt;
  logic [REQ_NUMBER-1:0] grant;
  logic [RW-1:0]         grant_idx;
  logic                  take;
  logic [RW-1:0]         cur_idx;
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [REQ_NUMBER-1:0] rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic [DEC_NUMBER-1:0] pselx;
  logic                  penable;
  logic [REQ_NUMBER-1:0] req_ready;

  assign take = !rst_i && (state != ST_SETUP) && (|bus.req_valid_i);

`ifdef APB_REQ_ARB_FIXED_PRIO_EN
  logic [RW-1:0] ii;
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    ii        = '0;
    for (int i = REQ_NUMBER - 1; i >= 0; i--) begin
      ii = RW'(i);
      if (bus.req_valid_i[ii]) begin
        grant     = '0;
        grant[ii] = 1'b1;
        grant_idx = ii;
      end
    end
  end
`else
  rr_arbiter #(.N(REQ_NUMBER)) u_rr_arbiter (
    .clk       (clk_i),
    .rst       (rst_i),
    .req       (bus.req_valid_i),
    .advance   (take),
    .grant     (grant),
    .grant_idx (grant_idx)
  );
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (take) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = take ? ST_SETUP : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pselx     = '0;
    penable   = 1'b0;
    req_ready = take ? grant : '0;
    if (!rst_i && (state == ST_SETUP || state == ST_ACCESS)) begin
      pselx[paddr[DEC_LSB +: IW]] = 1'b1;
      penable = (state == ST_ACCESS);
    end
  end

  // Response is built from the transfer finishing now; a grant on the same edge only touches the payload.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur_idx   <= '0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      if (state == ST_ACCESS) begin
        rsp_valid <= REQ_NUMBER'(1) << cur_idx;
        rsp_rdata <= pwrite ? '0 : bus.prdata_i;
      end
      if (take) begin
        cur_idx <= grant_idx;
        paddr   <= bus.req_addr_i[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
        pwrite  <= bus.req_write_i[grant_idx];
        pwdata  <= bus.req_wdata_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.req_ready_o = req_ready;
  assign bus.pselx_o     = pselx;
  assign bus.penable_o   = penable;
  assign bus.paddr_o     = rst_i ? '0 : paddr;
  assign bus.pwrite_o    = rst_i ? 1'b0 : pwrite;
  assign bus.pwdata_o    = rst_i ? '0 : pwdata;
  assign bus.rsp_valid_o = rst_i ? '0 : rsp_valid;
  assign bus.rsp_rdata_o = rst_i ? '0 : rsp_rdata;

endmodule

// File: tb/tb_apb_req_arb.sv
// tb/tb_apb_req_arb.sv - directed and randomized self-checking bench for apb_req_arb
module tb_apb_req_arb;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int DN = 16;
  localparam int DL = 12;
  localparam int RN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  apb_req_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEC_NUMBER(DN), .REQ_NUMBER(RN)) bus ();

  apb_req_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEC_NUMBER(DN), .DEC_LSB(DL), .REQ_NUMBER(RN)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid_i[i]          = v;
    bus.req_write_i[i]          = w;
    bus.req_addr_i[i*AW +: AW]  = a;
    bus.req_wdata_i[i*DW +: DW] = d;
  endtask

  task automatic clear_all();
    bus.req_valid_i = '0;
    bus.req_write_i = '0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    bus.prdata_i    = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < RN; i++) set_req(i, 1'b1, 1'b1, 32'hFFFF_FFFF, 64'h1);
    @(negedge clk);
    n_checks++;
    if (bus.req_ready_o !== 4'b0 || bus.pselx_o !== 16'h0 || bus.penable_o !== 1'b0 || bus.rsp_valid_o !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready=%b psel=%h pen=%b rsp=%b required all zero",
               bus.req_ready_o, bus.pselx_o, bus.penable_o, bus.rsp_valid_o);
    end
    n_checks++;
    if ({bus.paddr_o, bus.pwrite_o, bus.pwdata_o, bus.rsp_rdata_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: paddr=%h pwrite=%b pwdata=%h rdata=%h required zero",
               bus.paddr_o, bus.pwrite_o, bus.pwdata_o, bus.rsp_rdata_o);
    end
    tick();
    rst = 1'b0;
    clear_all();
    @(negedge clk);
    n_checks++;
    if (bus.pselx_o !== 16'h0 || bus.req_ready_o !== 4'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: psel=%h ready=%b required 0", bus.pselx_o, bus.req_ready_o);
    end
    tick();
  endtask

  task automatic test_single_read();
    set_req(1, 1'b1, 1'b0, 32'h0000_3004, 64'h0);
    bus.prdata_i = 64'hDEAD_BEEF;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready_o !== 4'b0010) begin
      n_fail++;
      $display("FAIL rd_grant: ready=%b required 0010", bus.req_ready_o);
    end
    tick();
    set_req(1, 1'b0, 1'b0, 32'h0, 64'h0);
    @(negedge clk);
    n_checks++;
    if (bus.pselx_o !== 16'h0008 || bus.penable_o !== 1'b0 || bus.paddr_o !== 32'h3004 || bus.pwrite_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_setup: psel=%h pen=%b paddr=%h pwrite=%b required 0008 0 3004 0",
               bus.pselx_o, bus.penable_o, bus.paddr_o, bus.pwrite_o);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (bus.pselx_o !== 16'h0008 || bus.penable_o !== 1'b1 || bus.paddr_o !== 32'h3004) begin
      n_fail++;
      $display("FAIL rd_access: psel=%h pen=%b paddr=%h required 0008 1 3004", bus.pselx_o, bus.penable_o, bus.paddr_o);
    end
    tick();
    bus.prdata_i = 64'h1234_5678;
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid_o !== 4'b0010 || bus.rsp_rdata_o !== 64'hDEAD_BEEF || bus.pselx_o !== 16'h0) begin
      n_fail++;
      $display("FAIL rd_rsp: rsp=%b rdata=%h psel=%h required 0010 deadbeef 0",
               bus.rsp_valid_o, bus.rsp_rdata_o, bus.pselx_o);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid_o !== 4'b0) begin
      n_fail++;
      $display("FAIL rd_rsp_pulse: rsp=%b required 0000", bus.rsp_valid_o);
    end
    tick();
  endtask

  task automatic test_single_write();
    set_req(0, 1'b1, 1'b1, 32'h0000_F000, 64'hA5);
    bus.prdata_i = 64'hCAFE_F00D_0BAD_BEEF;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready_o !== 4'b0001) begin
      n_fail++;
      $display("FAIL wr_grant: ready=%b required 0001", bus.req_ready_o);
    end
    tick();
    set_req(0, 1'b0, 1'b0, 32'h0, 64'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.pselx_o !== 16'h8000 || bus.penable_o !== (k == 1) || bus.pwrite_o !== 1'b1 ||
          bus.pwdata_o !== 64'hA5 || bus.paddr_o !== 32'hF000) begin
        n_fail++;
        $display("FAIL wr_phase%0d: psel=%h pen=%b pwrite=%b pwdata=%h paddr=%h required 8000 %0d 1 a5 f000",
                 k, bus.pselx_o, bus.penable_o, bus.pwrite_o, bus.pwdata_o, bus.paddr_o, k);
      end
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid_o !== 4'b0001 || bus.rsp_rdata_o !== 64'h0) begin
      n_fail++;
      $display("FAIL wr_rsp: rsp=%b rdata=%h required 0001 0", bus.rsp_valid_o, bus.rsp_rdata_o);
    end
    tick();
  endtask

`ifndef APB_REQ_ARB_FIXED_PRIO_EN
  task automatic test_back_to_back();
    logic [RN-1:0] exp_ready, exp_rsp;
    logic [DN-1:0] exp_psel;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < RN; i++) set_req(i, 1'b1, 1'b0, AW'(i << DL), DW'(i));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      exp_ready = (k % 2 == 0) ? RN'(1) << ((k / 2) % RN) : '0;
      exp_psel  = (k == 0) ? '0 : DN'(1) << (((k - 1) / 2) % RN);
      exp_rsp   = (k >= 3 && k % 2 == 1) ? RN'(1) << (((k - 3) / 2) % RN) : '0;
      n_checks++;
      if (bus.req_ready_o !== exp_ready || bus.pselx_o !== exp_psel || bus.rsp_valid_o !== exp_rsp ||
          bus.penable_o !== (k > 0 && k % 2 == 0)) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: ready=%b psel=%h rsp=%b pen=%b required %b %h %b %0d",
                 k, bus.req_ready_o, bus.pselx_o, bus.rsp_valid_o, bus.penable_o,
                 exp_ready, exp_psel, exp_rsp, (k > 0 && k % 2 == 0));
      end
      tick();
    end
    clear_all();
    repeat (4) tick();
  endtask

  task automatic test_reset_abort();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < RN; i++) set_req(i, 1'b1, 1'b0, AW'(i << DL), DW'(i));
    repeat (5) tick();
    @(negedge clk);
    n_checks++;
    if (bus.pselx_o !== 16'h0004 || bus.penable_o !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_setup2: psel=%h pen=%b required 0004 0", bus.pselx_o, bus.penable_o);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.pselx_o !== 16'h0 || bus.penable_o !== 1'b0 || bus.rsp_valid_o !== 4'b0 || bus.req_ready_o !== 4'b0001) begin
      n_fail++;
      $display("FAIL abort_next: psel=%h pen=%b rsp=%b ready=%b required 0 0 0000 0001",
               bus.pselx_o, bus.penable_o, bus.rsp_valid_o, bus.req_ready_o);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid_o !== 4'b0 || bus.pselx_o !== 16'h0001) begin
      n_fail++;
      $display("FAIL abort_no_rsp: rsp=%b psel=%h required 0000 0001", bus.rsp_valid_o, bus.pselx_o);
    end
    clear_all();
    repeat (4) tick();
  endtask
`else
  task automatic test_fixed_prio();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h0, 64'h0);
    set_req(3, 1'b1, 1'b0, 32'h3000, 64'h0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.req_ready_o !== ((k % 2 == 0) ? 4'b0001 : 4'b0000)) begin
        n_fail++;
        $display("FAIL fixed_prio_cycle%0d: ready=%b required %b", k, bus.req_ready_o,
                 (k % 2 == 0) ? 4'b0001 : 4'b0000);
      end
      tick();
    end
    clear_all();
    repeat (4) tick();
  endtask
`endif

  task automatic test_random();
    bit            mv[RN];
    bit            mw[RN];
    logic [AW-1:0] ma[RN];
    logic [DW-1:0] md[RN];
    int            t_cyc[4];
    int            t_idx[4];
    logic [AW-1:0] t_a[4];
    bit            t_w[4];
    logic [DW-1:0] t_d[4];
    logic [DW-1:0] t_rd[4];
    int            last_idx, last_cyc, base, exp_g, s1, s2, s3, sa;
    logic [RN-1:0] exp_ready, exp_rsp;
    logic [DN-1:0] exp_psel;
    logic [DW-1:0] exp_rd;
    bit            exp_pen, active;
    rst = 1'b1;
    clear_all();
    tick();
    rst = 1'b0;
    for (int i = 0; i < RN; i++) mv[i] = 1'b0;
    for (int s = 0; s < 4; s++) t_cyc[s] = -100;
    last_idx = RN - 1;
    last_cyc = -10;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < RN; i++) begin
        if (!mv[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            mv[i] = 1'b1;
            ma[i] = $urandom;
            mw[i] = 1'($urandom_range(0, 1));
            md[i] = {$urandom, $urandom};
          end
        end else if ($urandom_range(0, 19) == 0) begin
          mv[i] = 1'b0;
        end
        set_req(i, mv[i], mw[i], ma[i], md[i]);
      end
      bus.prdata_i = {$urandom, $urandom};
      @(negedge clk);
      // Free to grant unless a transfer was granted last cycle.
      exp_g = -1;
`ifdef APB_REQ_ARB_FIXED_PRIO_EN
      base = RN - 1;
`else
      base = last_idx;
`endif
      if (last_cyc != c - 1)
        for (int k = 1; k <= RN; k++)
          if (exp_g < 0 && mv[(base + k) % RN]) exp_g = (base + k) % RN;
      exp_ready = (exp_g >= 0) ? RN'(1) << exp_g : '0;
      n_checks++;
      if (bus.req_ready_o !== exp_ready) begin
        n_fail++;
        $display("FAIL rnd_grant c=%0d: ready=%b required %b", c, bus.req_ready_o, exp_ready);
      end
      s1 = (c + 3) % 4;
      s2 = (c + 2) % 4;
      s3 = (c + 1) % 4;
      exp_psel = '0;
      exp_pen  = 1'b0;
      active   = 1'b0;
      sa       = 0;
      if (t_cyc[s1] == c - 1) begin
        active = 1'b1;
        sa     = s1;
      end else if (t_cyc[s2] == c - 2) begin
        active   = 1'b1;
        sa       = s2;
        exp_pen  = 1'b1;
        t_rd[s2] = bus.prdata_i;
      end
      if (active) exp_psel[t_a[sa][DL +: 4]] = 1'b1;
      n_checks++;
      if (bus.pselx_o !== exp_psel || bus.penable_o !== exp_pen) begin
        n_fail++;
        $display("FAIL rnd_apb_ctrl c=%0d: psel=%h pen=%b required %h %b", c, bus.pselx_o, bus.penable_o, exp_psel, exp_pen);
      end
      if (active) begin
        n_checks++;
        if ({bus.paddr_o, bus.pwrite_o, bus.pwdata_o} !== {t_a[sa], t_w[sa], t_d[sa]}) begin
          n_fail++;
          $display("FAIL rnd_apb_data c=%0d: paddr=%h pwrite=%b pwdata=%h required %h %b %h",
                   c, bus.paddr_o, bus.pwrite_o, bus.pwdata_o, t_a[sa], t_w[sa], t_d[sa]);
        end
      end
      exp_rsp = '0;
      exp_rd  = '0;
      if (t_cyc[s3] == c - 3) begin
        exp_rsp = RN'(1) << t_idx[s3];
        exp_rd  = t_w[s3] ? '0 : t_rd[s3];
      end
      n_checks++;
      if (bus.rsp_valid_o !== exp_rsp || (exp_rsp != '0 && bus.rsp_rdata_o !== exp_rd)) begin
        n_fail++;
        $display("FAIL rnd_rsp c=%0d: rsp=%b rdata=%h required %b %h", c, bus.rsp_valid_o, bus.rsp_rdata_o, exp_rsp, exp_rd);
      end
      if (exp_g >= 0) begin
        t_cyc[c % 4] = c;
        t_idx[c % 4] = exp_g;
        t_a[c % 4]   = ma[exp_g];
        t_w[c % 4]   = mw[exp_g];
        t_d[c % 4]   = md[exp_g];
        last_idx     = exp_g;
        last_cyc     = c;
        mv[exp_g]    = 1'b0;
      end
      tick();
    end
    clear_all();
    repeat (4) tick();
  endtask

  initial begin
    clear_all();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_read();
    test_single_write();
`ifndef APB_REQ_ARB_FIXED_PRIO_EN
    test_back_to_back();
    test_reset_abort();
`else
    test_fixed_prio();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
